// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package pc_seq_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0080;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Program-counter register: synchronous clear to RESET_PC, load enable.
module pc_reg
  import pc_seq_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              ld,
  input  logic [INST_W-1:0] d,
  output logic [INST_W-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Clr)
      q <= RESET_PC;
    else if (ld)
      q <= d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack and core valid/ready handshakes.
// Optional exception redirect (Exc/Epc ports, EXC_VEC) enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
`ifdef PC_SEQ_EXC_EN
  , parameter logic [INST_W-1:0] EXC_VEC = EXC_VEC_DEF
`endif
) (
  input  logic              Clk,
  input  logic              Clr,
  output logic              Imem_req,
  output logic [INST_W-1:0] Imem_addr,
  input  logic              Imem_ack,
  input  logic [INST_W-1:0] Imem_data,
  output logic              Inst_valid,
  output logic [INST_W-1:0] Inst,
  output logic [INST_W-1:0] Inst_pc,
  input  logic              Inst_ready,
  input  logic              Redirect,
  input  logic [INST_W-1:0] Redirect_addr,
  input  logic              Halt,
`ifdef PC_SEQ_EXC_EN
  input  logic              Exc,
  output logic [INST_W-1:0] Epc,
`endif
  output logic              Halted
);

  state_t            state, state_nxt;
  logic [INST_W-1:0] pc, pc_d;
  logic              pc_ld;
  logic              hs;
  logic              fetch_done;

  assign hs         = (state == ISSUE) && Inst_ready;
  assign fetch_done = (state == FETCH) && Imem_ack;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .Clk (Clk),
    .Clr (Clr),
    .ld  (pc_ld),
    .d   (pc_d),
    .q   (pc)
  );

  always_ff @(posedge Clk) begin
    if (Clr)
      state <= BOOT;
    else
      state <= state_nxt;
  end

  // Next state and next PC; redirect sources are only honoured on the handshake cycle.
  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    pc_d      = pc;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: if (Imem_ack) state_nxt = ISSUE;
      ISSUE: begin
        if (hs) begin
          pc_ld     = 1'b1;
          state_nxt = FETCH;
`ifdef PC_SEQ_EXC_EN
          if (Exc)
            pc_d = EXC_VEC;
          else
`endif
          if (Halt) begin
            pc_d      = Inst_pc + 32'd4;
            state_nxt = HALT;
          end else if (Redirect)
            pc_d = word_align(Redirect_addr);
          else
            pc_d = pc + 32'd4;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    Imem_req   = (state == FETCH);
    Inst_valid = (state == ISSUE);
    Halted     = (state == HALT);
  end

  assign Imem_addr = pc;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      Inst    <= '0;
      Inst_pc <= '0;
    end else if (fetch_done) begin
      Inst    <= Imem_data;
      Inst_pc <= pc;
    end
  end

`ifdef PC_SEQ_EXC_EN
  always_ff @(posedge Clk) begin
    if (Clr)
      Epc <= '0;
    else if (hs && Exc)
      Epc <= Inst_pc;
  end
`endif

endmodule
